// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (instruction/data) arbiter onto a single-ported word
//            SRAM with a fixed 1-cycle registered response. Optional macro
//            MEM_ARB_ERR_EN adds out-of-range detection and i_err/d_err.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4096,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata
`ifdef MEM_ARB_ERR_EN
  ,
  output logic                i_err,
  output logic                d_err
`endif
);

  localparam int         c_idx_w = $clog2(DEPTH);
  localparam int         c_nb    = DATA_W / 8;
  localparam logic [3:0] c_limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t               r_owner;
  owner_t               w_owner_nxt;
  logic [3:0]           r_starve;
  logic [3:0]           w_starve_nxt;
  logic                 w_gnt_i;
  logic                 w_gnt_d;
  logic [c_idx_w-1:0]   w_idx;
  logic [DATA_W-1:0]    w_rd_word;
  logic                 w_oob;
  logic                 w_wr_en;
  logic [DATA_W-1:0]    r_i_rdata;
  logic [DATA_W-1:0]    r_d_rdata;
  logic [DATA_W-1:0]    r_mem [DEPTH];

  // Arbitration: D wins ties until I has been denied STARVE_LIMIT cycles in a row.
  always_comb begin
    w_gnt_i      = 1'b0;
    w_gnt_d      = 1'b0;
    w_owner_nxt  = OWN_NONE;
    w_starve_nxt = r_starve;
    if (!rst) begin
      if (i_req && (!d_req || (r_starve >= c_limit))) begin
        w_gnt_i = 1'b1;
      end else if (d_req) begin
        w_gnt_d = 1'b1;
      end
    end
    if (w_gnt_i) begin
      w_owner_nxt = OWN_I;
    end else if (w_gnt_d) begin
      w_owner_nxt = OWN_D;
    end
    if (!i_req || w_gnt_i) begin
      w_starve_nxt = 4'd0;
    end else if (r_starve < c_limit) begin
      w_starve_nxt = r_starve + 4'd1;
    end
  end

  assign w_idx     = w_gnt_i ? i_addr[2 +: c_idx_w] : d_addr[2 +: c_idx_w];
  assign w_rd_word = r_mem[w_idx];

`ifdef MEM_ARB_ERR_EN
  logic w_i_oob;
  logic w_d_oob;
  logic r_i_err;
  logic r_d_err;

  assign w_i_oob = |i_addr[ADDR_W-1:c_idx_w+2];
  assign w_d_oob = |d_addr[ADDR_W-1:c_idx_w+2];
  assign w_oob   = w_gnt_i ? w_i_oob : w_d_oob;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_err <= 1'b0;
      r_d_err <= 1'b0;
    end else begin
      if (w_gnt_i) r_i_err <= w_i_oob;
      if (w_gnt_d) r_d_err <= w_d_oob;
    end
  end

  assign i_err = r_i_err;
  assign d_err = r_d_err;

  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, i_addr[1:0], d_addr[1:0]};
`else
  assign w_oob = 1'b0;

  // Upper address bits alias onto the SRAM in this build.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, i_addr[1:0], d_addr[1:0],
                           i_addr[ADDR_W-1:c_idx_w+2], d_addr[ADDR_W-1:c_idx_w+2]};
`endif

  assign w_wr_en = w_gnt_d && d_we && !w_oob;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < c_nb; k++) begin
        if (d_be[k]) r_mem[w_idx][8*k +: 8] <= d_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner   <= OWN_NONE;
      r_starve  <= 4'd0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_starve <= w_starve_nxt;
      if (w_gnt_i) r_i_rdata <= w_oob ? '0 : w_rd_word;
      // Write responses return zero data.
      if (w_gnt_d) r_d_rdata <= (d_we || w_oob) ? '0 : w_rd_word;
    end
  end

  assign i_gnt    = w_gnt_i;
  assign d_gnt    = w_gnt_d;
  assign i_rvalid = (r_owner == OWN_I);
  assign d_rvalid = (r_owner == OWN_D);
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter: directed cases plus randomized
//            traffic against a word-array reference model (MEM_ARB_ERR_EN aware).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int DEPTH = 4096;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        i_err_t, d_err_t;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata)
`ifdef MEM_ARB_ERR_EN
    ,
    .i_err(i_err_t), .d_err(d_err_t)
`endif
  );

`ifndef MEM_ARB_ERR_EN
  assign i_err_t = 1'b0;
  assign d_err_t = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  int rv_seen = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] mem_m [int];
  int          starve_m = 0;

  function automatic bit oob(input logic [31:0] a);
`ifdef MEM_ARB_ERR_EN
    return (a >> 2) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (oob(a)) return 32'h0;
    if (mem_m.exists(widx(a))) return mem_m[widx(a)];
    return 32'h0;
  endfunction

  // Monitor: pops the scoreboard whenever a port presents rvalid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rv_seen += int'(i_rvalid) + int'(d_rvalid);
        if (i_rvalid) begin
          checks++;
          if (iq.size() == 0) begin
            errors++;
            $display("FAIL i_unexpected_rvalid: got rvalid=1 required 0 at cycle %0d", cyc);
          end else begin
            e = iq.pop_front();
            if (i_rdata !== e.data || i_err_t !== e.err || cyc != e.cyc) begin
              errors++;
              $display("FAIL i_resp: got data=%h err=%b cyc=%0d required data=%h err=%b cyc=%0d",
                       i_rdata, i_err_t, cyc, e.data, e.err, e.cyc);
            end
          end
        end else if (iq.size() != 0 && iq[0].cyc <= cyc) begin
          checks++; errors++;
          e = iq.pop_front();
          $display("FAIL i_missing_rvalid: got rvalid=0 required 1 at cycle %0d", e.cyc);
        end
        if (d_rvalid) begin
          checks++;
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL d_unexpected_rvalid: got rvalid=1 required 0 at cycle %0d", cyc);
          end else begin
            e = dq.pop_front();
            if (d_rdata !== e.data || d_err_t !== e.err || cyc != e.cyc) begin
              errors++;
              $display("FAIL d_resp: got data=%h err=%b cyc=%0d required data=%h err=%b cyc=%0d",
                       d_rdata, d_err_t, cyc, e.data, e.err, e.cyc);
            end
          end
        end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
          checks++; errors++;
          e = dq.pop_front();
          $display("FAIL d_missing_rvalid: got rvalid=0 required 1 at cycle %0d", e.cyc);
        end
      end
    end
  end

  // One request cycle: drive, check grants, push expected responses.
  task automatic drive_cycle(input logic ir, input logic [31:0] ia,
                             input logic dr, input logic dw, input logic [3:0] db,
                             input logic [31:0] da, input logic [31:0] dd,
                             output logic gi, output logic gd);
    logic        egi, egd;
    logic [31:0] w;
    @(negedge clk);
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dd;
    #1;
    egi = ir && (!dr || starve_m >= LIMIT);
    egd = dr && !egi;
    gi = i_gnt;
    gd = d_gnt;
    checks++;
    if (gi !== egi || gd !== egd) begin
      errors++;
      $display("FAIL gnt: got i_gnt=%b d_gnt=%b required i_gnt=%b d_gnt=%b at cycle %0d",
               gi, gd, egi, egd, cyc);
    end
    if (egi) iq.push_back('{rd_model(ia), oob(ia), cyc + 1});
    if (egd) begin
      if (dw) begin
        dq.push_back('{32'h0, oob(da), cyc + 1});
        if (!oob(da)) begin
          w = rd_model(da);
          for (int k = 0; k < 4; k++) if (db[k]) w[8*k +: 8] = dd[8*k +: 8];
          mem_m[widx(da)] = w;
        end
      end else begin
        dq.push_back('{rd_model(da), oob(da), cyc + 1});
      end
    end
    if (ir && !egi) starve_m = (starve_m < LIMIT) ? starve_m + 1 : LIMIT;
    else            starve_m = 0;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err_t, d_err_t} !== 6'b0 ||
        i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s: got gnt=%b%b rvalid=%b%b err=%b%b i_rdata=%h d_rdata=%h required all 0",
               name, i_gnt, d_gnt, i_rvalid, d_rvalid, i_err_t, d_err_t, i_rdata, d_rdata);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) a = a | 32'h4000;
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        gi, gd;
    logic        p_ir, p_dr, p_dw;
    logic [31:0] p_ia, p_da, p_dd;
    logic [3:0]  p_db;
    logic        exp_pat [10];

    #1 check_zero("reset_state");
    #20;
    @(negedge clk) rst = 1'b0;

    // Asynchronous reset pulse in mid-cycle while idle, then 5 idle cycles.
    @(posedge clk); #2 rst = 1'b1;
    #1 check_zero("async_pulse");
    @(posedge clk); #2 rst = 1'b0;
    rv_seen = 0;
    repeat (5) drive_cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
    checks++;
    if (rv_seen != 0) begin
      errors++;
      $display("FAIL idle_after_reset: got %0d rvalids required 0", rv_seen);
    end

    for (int k = 0; k < 8; k++)
      drive_cycle(0, 0, 1, 1, 4'hF, 32'(k * 4), $urandom, gi, gd);

    drive_cycle(0, 0, 1, 1, 4'b1111, 32'h10, 32'hDEADBEEF, gi, gd);
    drive_cycle(0, 0, 1, 0, 4'b0000, 32'h10, 32'h0, gi, gd);
    drive_cycle(0, 0, 1, 1, 4'b0001, 32'h10, 32'h000000AA, gi, gd);
    drive_cycle(0, 0, 1, 0, 4'b0000, 32'h10, 32'h0, gi, gd);

    // I read immediately after a D write to the same word.
    drive_cycle(0, 0, 1, 1, 4'b1111, 32'h10, 32'h12345678, gi, gd);
    drive_cycle(1, 32'h10, 0, 0, 0, 0, 0, gi, gd);

    drive_cycle(0, 0, 1, 1, 4'b1111, 32'h4000, 32'hCAFEF00D, gi, gd);
    drive_cycle(0, 0, 1, 0, 4'b0000, 32'h4000, 32'h0, gi, gd);
    drive_cycle(0, 0, 1, 0, 4'b0000, 32'h0, 32'h0, gi, gd);

    // Build starvation to 3, reset right after a D read grant.
    drive_cycle(1, 32'h0, 1, 0, 0, 32'h4, 0, gi, gd);
    drive_cycle(1, 32'h0, 1, 0, 0, 32'h8, 0, gi, gd);
    drive_cycle(1, 32'h0, 1, 0, 0, 32'hC, 0, gi, gd);
    #2 rst = 1'b1;
    iq.delete(); dq.delete(); starve_m = 0;
    #1 check_zero("reset_mid_op");
    @(posedge clk); #2 rst = 1'b0;

    exp_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int n = 0; n < 10; n++) begin
      drive_cycle(1, 32'(n * 4 % 32), 1, 0, 0, 32'((n + 3) * 4 % 32), 0, gi, gd);
      checks++;
      if (gi !== exp_pat[n] || gd !== !exp_pat[n]) begin
        errors++;
        $display("FAIL starve_seq[%0d]: got i_gnt=%b d_gnt=%b required i_gnt=%b d_gnt=%b",
                 n, gi, gd, exp_pat[n], !exp_pat[n]);
      end
    end

    p_ir = 0; p_dr = 0; p_dw = 0; p_ia = 0; p_da = 0; p_dd = 0; p_db = 0;
    for (int n = 0; n < 300; n++) begin
      if (!p_ir) begin
        if ($urandom_range(0, 9) < 6) begin p_ir = 1; p_ia = rand_addr(); end
      end else if ($urandom_range(0, 19) == 0) p_ir = 0;
      if (!p_dr) begin
        if ($urandom_range(0, 9) < 6) begin
          p_dr = 1; p_dw = 1'($urandom_range(0, 1)); p_db = 4'($urandom_range(0, 15));
          p_da = rand_addr(); p_dd = $urandom;
        end
      end else if ($urandom_range(0, 19) == 0) p_dr = 0;
      drive_cycle(p_ir, p_ia, p_dr, p_dw, p_db, p_da, p_dd, gi, gd);
      if (gi) p_ir = 0;
      if (gd) p_dr = 0;
    end

    repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 0, gi, gd);
    checks++;
    if (iq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d outstanding responses required 0/0", iq.size(), dq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
